// File: rtl/id_ex_if.sv
// id_ex_if: ID-side inputs, forwarding sources and EX-side outputs of the ID/EX stage
interface id_ex_if #(parameter int XLEN = 32);
  logic            id_valid;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [3:0]      id_alu_ctrl;
  logic            id_alu_b_sel;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic            hold_in, flush_in;
  logic [4:0]      exmem_rd, memwb_rd;
  logic            exmem_reg_write, memwb_reg_write;
  logic [XLEN-1:0] exmem_result, memwb_result;
  logic            ex_valid;
  logic [XLEN-1:0] a, b, imm_gen_out, pc_out;
  logic [3:0]      alu_ctrl;
  logic            alu_b_sel;
  logic [4:0]      ex_rd;
  logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic            stall_out;
  modport slave (
    input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_pc, id_alu_ctrl, id_alu_b_sel,
           id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           id_branch, hold_in, flush_in, exmem_rd, memwb_rd, exmem_reg_write,
           memwb_reg_write, exmem_result, memwb_result,
    output ex_valid, a, b, imm_gen_out, pc_out, alu_ctrl, alu_b_sel, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, stall_out
  );
  modport master (
    output id_valid, id_rs1_data, id_rs2_data, id_imm, id_pc, id_alu_ctrl, id_alu_b_sel,
           id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           id_branch, hold_in, flush_in, exmem_rd, memwb_rd, exmem_reg_write,
           memwb_reg_write, exmem_result, memwb_result,
    input  ex_valid, a, b, imm_gen_out, pc_out, alu_ctrl, alu_b_sel, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, stall_out
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with load-use bubbles, hold/flush and bubble counter.
// Define FWD_EN to add EX/MEM and MEM/WB operand forwarding.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_if.slave           bus,
  output logic [CNT_W-1:0] bubble_cnt
);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rs1_data, rs2_data, imm, pc;
    logic [3:0]      alu_ctrl;
    logic            alu_b_sel;
`ifdef FWD_EN
    logic [4:0]      rs1, rs2;
`endif
    logic [4:0]      rd;
    logic            reg_write, mem_read, mem_write, mem_to_reg, branch;
  } ex_t;
  ex_t ex_q, ex_d, ld;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic haz_src, ld_use, bubble;
  always_comb begin
    // without forwarding, any older writer still in EX must be waited out
`ifdef FWD_EN
    haz_src = ex_q.mem_read;
`else
    haz_src = ex_q.mem_read | ex_q.reg_write;
`endif
    ld_use = ex_q.valid & haz_src & (ex_q.rd != 5'd0) & bus.id_valid &
             ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));
    bubble = bus.flush_in | ld_use;
    ld = '0;
    ld.valid      = bus.id_valid;
    ld.rs1_data   = bus.id_rs1_data;
    ld.rs2_data   = bus.id_rs2_data;
    ld.imm        = bus.id_imm;
    ld.pc         = bus.id_pc;
    ld.alu_ctrl   = bus.id_alu_ctrl;
    ld.alu_b_sel  = bus.id_alu_b_sel;
`ifdef FWD_EN
    ld.rs1        = bus.id_rs1;
    ld.rs2        = bus.id_rs2;
`endif
    ld.rd         = bus.id_rd;
    ld.reg_write  = bus.id_valid & bus.id_reg_write;
    ld.mem_read   = bus.id_valid & bus.id_mem_read;
    ld.mem_write  = bus.id_valid & bus.id_mem_write;
    ld.mem_to_reg = bus.id_valid & bus.id_mem_to_reg;
    ld.branch     = bus.id_valid & bus.id_branch;
    ex_d = bus.hold_in ? ex_q : bubble ? '0 : ld;
    bubble_cnt_d = (!bus.hold_in && bubble && !(&bubble_cnt_q)) ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
`ifdef FWD_EN
  assign bus.a = (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == ex_q.rs1) ? bus.exmem_result :
                 (bus.memwb_reg_write && bus.memwb_rd != 5'd0 && bus.memwb_rd == ex_q.rs1) ? bus.memwb_result :
                 ex_q.rs1_data;
  assign bus.b = (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == ex_q.rs2) ? bus.exmem_result :
                 (bus.memwb_reg_write && bus.memwb_rd != 5'd0 && bus.memwb_rd == ex_q.rs2) ? bus.memwb_result :
                 ex_q.rs2_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.exmem_rd, bus.memwb_rd, bus.exmem_reg_write, bus.memwb_reg_write,
                        bus.exmem_result, bus.memwb_result};
  assign bus.a = ex_q.rs1_data;
  assign bus.b = ex_q.rs2_data;
`endif
  assign bus.ex_valid      = ex_q.valid;
  assign bus.imm_gen_out   = ex_q.imm;
  assign bus.pc_out        = ex_q.pc;
  assign bus.alu_ctrl      = ex_q.alu_ctrl;
  assign bus.alu_b_sel     = ex_q.alu_b_sel;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.stall_out     = bus.hold_in | ld_use;
  assign bubble_cnt        = bubble_cnt_q;
endmodule
